// File: rtl/pe_dbw_if.sv
// ----------------------------------------------------------------------------
// pe_dbw_if
// Bundles the load chain, activation, partial-sum and status signals of one
// pe_dbw processing element. Clock and reset are not part of the bundle.
//
// Signals (direction as seen by the PE, i.e. the slave modport):
//   PE_w_en_up / PE_w_data_up / PE_w_row_up        in   weight-load beat
//   PE_w_en_down / PE_w_data_down / PE_w_row_down  out  load chain forward
//   PE_swap                                        in   commit shadow bank
//   PE_en_left / PE_data_left / PE_idx_left        in   activation + index
//   PE_en_right / PE_data_right / PE_idx_right     out  activation forward
//   PE_psum_up                                     in   partial sum from above
//   PE_psum_down / PE_en_down                      out  partial sum result
//   PE_shadow_full                                 out  shadow bank filled
//
// Modports:
//   master - the neighbour / driver side
//   slave  - the PE side
// ----------------------------------------------------------------------------
interface pe_dbw_if #(
    parameter int D_WIDTH = 9,
    parameter int A_WIDTH = 32,
    parameter int N_W     = 4,
    parameter int R_WIDTH = 4
);
    localparam int IDX_W = $clog2(N_W);

    // Load chain
    logic                      PE_w_en_up;
    logic signed [D_WIDTH-1:0] PE_w_data_up;
    logic [R_WIDTH-1:0]        PE_w_row_up;
    logic                      PE_w_en_down;
    logic signed [D_WIDTH-1:0] PE_w_data_down;
    logic [R_WIDTH-1:0]        PE_w_row_down;
    logic                      PE_swap;

    // Activation path
    logic                      PE_en_left;
    logic signed [D_WIDTH-1:0] PE_data_left;
    logic [IDX_W-1:0]          PE_idx_left;
    logic                      PE_en_right;
    logic signed [D_WIDTH-1:0] PE_data_right;
    logic [IDX_W-1:0]          PE_idx_right;

    // Partial-sum path and status
    logic signed [A_WIDTH-1:0] PE_psum_up;
    logic signed [A_WIDTH-1:0] PE_psum_down;
    logic                      PE_en_down;
    logic                      PE_shadow_full;

    modport master (
        output PE_w_en_up, PE_w_data_up, PE_w_row_up, PE_swap,
        output PE_en_left, PE_data_left, PE_idx_left, PE_psum_up,
        input  PE_w_en_down, PE_w_data_down, PE_w_row_down,
        input  PE_en_right, PE_data_right, PE_idx_right,
        input  PE_psum_down, PE_en_down, PE_shadow_full
    );

    modport slave (
        input  PE_w_en_up, PE_w_data_up, PE_w_row_up, PE_swap,
        input  PE_en_left, PE_data_left, PE_idx_left, PE_psum_up,
        output PE_w_en_down, PE_w_data_down, PE_w_row_down,
        output PE_en_right, PE_data_right, PE_idx_right,
        output PE_psum_down, PE_en_down, PE_shadow_full
    );

endinterface

// File: rtl/pe_dbw.sv
// ----------------------------------------------------------------------------
// pe_dbw
// Systolic processing element with a double-buffered, N_W-entry weight bank.
// Weights arriving on the load chain for this row fill a shadow bank; a swap
// pulse copies the whole shadow bank into the active bank in one cycle.
// Each activation selects its weight from the active bank by index, and the
// PE produces psum_down = data * active[idx] + psum_up one cycle later.
//
// Ports:
//   PE_clk  in   clock, rising edge
//   PE_rst  in   asynchronous, active-high reset (clears banks and outputs)
//   bus     slave modport of pe_dbw_if (load chain, activation, psum, status)
//
// Build option:
//   PE_SAT_EN  when defined the final sum saturates to the A_WIDTH signed
//              range; otherwise it wraps modulo 2^A_WIDTH.
// ----------------------------------------------------------------------------
module pe_dbw #(
    parameter int D_WIDTH = 9,
    parameter int A_WIDTH = 32,   // must be >= 2*D_WIDTH+1
    parameter int N_W     = 4,    // power of two, >= 2
    parameter int R_WIDTH = 4,
    parameter int ROW_ID  = 0
) (
    input  logic     PE_clk,
    input  logic     PE_rst,
    pe_dbw_if.slave  bus
);

    localparam int                 IDX_W   = $clog2(N_W);
    localparam int                 P_WIDTH = 2 * D_WIDTH;
    localparam logic [R_WIDTH-1:0] ROW_SEL = R_WIDTH'(ROW_ID);
    localparam logic [IDX_W-1:0]   WPTR_LAST = IDX_W'(N_W - 1);

`ifdef PE_SAT_EN
    localparam logic signed [A_WIDTH-1:0] ACC_MAX = {1'b0, {(A_WIDTH-1){1'b1}}};
    localparam logic signed [A_WIDTH-1:0] ACC_MIN = {1'b1, {(A_WIDTH-1){1'b0}}};

    // One extra bit catches overflow; clamp when the top two bits disagree.
    function automatic logic signed [A_WIDTH-1:0] acc_add(
        input logic signed [A_WIDTH-1:0] a,
        input logic signed [A_WIDTH-1:0] b
    );
        logic signed [A_WIDTH:0] s;
        s = {a[A_WIDTH-1], a} + {b[A_WIDTH-1], b};
        if (s[A_WIDTH] != s[A_WIDTH-1])
            return s[A_WIDTH] ? ACC_MIN : ACC_MAX;
        return s[A_WIDTH-1:0];
    endfunction
`else
    // Two's-complement wrap modulo 2^A_WIDTH.
    function automatic logic signed [A_WIDTH-1:0] acc_add(
        input logic signed [A_WIDTH-1:0] a,
        input logic signed [A_WIDTH-1:0] b
    );
        return a + b;
    endfunction
`endif

    // Weight storage and load-side control
    logic signed [D_WIDTH-1:0] shadow_bank [N_W];
    logic signed [D_WIDTH-1:0] active_bank [N_W];
    logic [IDX_W-1:0]          wptr;
    logic                      shadow_full;

    // Registered outputs
    logic                      w_vld_p1;
    logic signed [D_WIDTH-1:0] w_data_p1;
    logic [R_WIDTH-1:0]        w_row_p1;
    logic                      act_vld_p1;
    logic signed [D_WIDTH-1:0] act_data_p1;
    logic [IDX_W-1:0]          act_idx_p1;
    logic                      psum_vld_p1;
    logic signed [A_WIDTH-1:0] psum_p1;

    // ---- stage p0: row match, weight lookup, multiply-accumulate ----
    logic                      shadow_wr_p0;
    logic signed [D_WIDTH-1:0] weight_p0;
    logic signed [P_WIDTH-1:0] prod_p0;
    logic signed [A_WIDTH-1:0] prod_ext_p0;
    logic signed [A_WIDTH-1:0] sum_p0;

    always_comb begin
        shadow_wr_p0 = bus.PE_w_en_up && (bus.PE_w_row_up == ROW_SEL);
        // Lookup uses the pre-swap active bank even in a swap cycle.
        weight_p0    = active_bank[bus.PE_idx_left];
        prod_p0      = bus.PE_data_left * weight_p0;
        prod_ext_p0  = {{(A_WIDTH-P_WIDTH){prod_p0[P_WIDTH-1]}}, prod_p0};
        sum_p0       = acc_add(prod_ext_p0, bus.PE_psum_up);
    end

    // ---- stage p1: bank update and output registers ----
    always_ff @(posedge PE_clk or posedge PE_rst) begin
        if (PE_rst) begin
            for (int i = 0; i < N_W; i++) begin
                shadow_bank[i] <= '0;
                active_bank[i] <= '0;
            end
            wptr        <= '0;
            shadow_full <= 1'b0;
            w_vld_p1    <= 1'b0;
            w_data_p1   <= '0;
            w_row_p1    <= '0;
            act_vld_p1  <= 1'b0;
            act_data_p1 <= '0;
            act_idx_p1  <= '0;
            psum_vld_p1 <= 1'b0;
            psum_p1     <= '0;
        end else begin
            // Every beat travels down the chain, whatever its row.
            w_vld_p1  <= bus.PE_w_en_up;
            w_data_p1 <= bus.PE_w_data_up;
            w_row_p1  <= bus.PE_w_row_up;

            // A write in the swap cycle still lands at the pre-clear wptr;
            // the copy below reads the old shadow contents, so it is not
            // carried into the active bank.
            if (shadow_wr_p0)
                shadow_bank[wptr] <= bus.PE_w_data_up;

            if (bus.PE_swap) begin
                for (int i = 0; i < N_W; i++)
                    active_bank[i] <= shadow_bank[i];
                wptr        <= '0;
                shadow_full <= 1'b0;
            end else if (shadow_wr_p0) begin
                wptr <= wptr + IDX_W'(1);
                if (wptr == WPTR_LAST)
                    shadow_full <= 1'b1;
            end

            act_vld_p1  <= bus.PE_en_left;
            psum_vld_p1 <= bus.PE_en_left;
            if (bus.PE_en_left) begin
                act_data_p1 <= bus.PE_data_left;
                act_idx_p1  <= bus.PE_idx_left;
                psum_p1     <= sum_p0;
            end
        end
    end

    assign bus.PE_w_en_down   = w_vld_p1;
    assign bus.PE_w_data_down = w_data_p1;
    assign bus.PE_w_row_down  = w_row_p1;
    assign bus.PE_en_right    = act_vld_p1;
    assign bus.PE_data_right  = act_data_p1;
    assign bus.PE_idx_right   = act_idx_p1;
    assign bus.PE_en_down     = psum_vld_p1;
    assign bus.PE_psum_down   = psum_p1;
    assign bus.PE_shadow_full = shadow_full;

endmodule

// File: tb/tb_pe_dbw.sv
// ----------------------------------------------------------------------------
// tb_pe_dbw
// Directed bench for pe_dbw (D_WIDTH=9, A_WIDTH=32, N_W=4, ROW_ID=0).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// ----------------------------------------------------------------------------
module tb_pe_dbw;

    localparam int D_WIDTH = 9;
    localparam int A_WIDTH = 32;
    localparam int N_W     = 4;
    localparam int R_WIDTH = 4;

    logic PE_clk;
    logic PE_rst;
    int   checks;
    int   errors;

    pe_dbw_if #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .N_W(N_W), .R_WIDTH(R_WIDTH)) bus ();

    pe_dbw #(
        .D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .N_W(N_W), .R_WIDTH(R_WIDTH), .ROW_ID(0)
    ) dut (
        .PE_clk (PE_clk),
        .PE_rst (PE_rst),
        .bus    (bus.slave)
    );

    initial PE_clk = 1'b0;
    always #5 PE_clk = ~PE_clk;

    task automatic tick();
        @(posedge PE_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [R_WIDTH-1:0] row, input logic signed [D_WIDTH-1:0] w);
        bus.PE_w_en_up   = 1'b1;
        bus.PE_w_row_up  = row;
        bus.PE_w_data_up = w;
        tick();
        bus.PE_w_en_up   = 1'b0;
    endtask

    task automatic swap();
        bus.PE_swap = 1'b1;
        tick();
        bus.PE_swap = 1'b0;
    endtask

    task automatic compute(input logic signed [D_WIDTH-1:0] d, input logic [1:0] idx,
                           input logic signed [A_WIDTH-1:0] ps);
        bus.PE_en_left   = 1'b1;
        bus.PE_data_left = d;
        bus.PE_idx_left  = idx;
        bus.PE_psum_up   = ps;
        tick();
        bus.PE_en_left   = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        PE_rst = 1'b1;
        bus.PE_w_en_up   = 1'b0;
        bus.PE_w_data_up = '0;
        bus.PE_w_row_up  = '0;
        bus.PE_swap      = 1'b0;
        bus.PE_en_left   = 1'b0;
        bus.PE_data_left = '0;
        bus.PE_idx_left  = '0;
        bus.PE_psum_up   = '0;
        tick();
        tick();

        // Reset state
        chk("rst_psum_down", bus.PE_psum_down, 32'd0);
        chk("rst_en_down", 32'(bus.PE_en_down), 32'd0);
        chk("rst_en_right", 32'(bus.PE_en_right), 32'd0);
        chk("rst_w_en_down", 32'(bus.PE_w_en_down), 32'd0);
        chk("rst_shadow_full", 32'(bus.PE_shadow_full), 32'd0);
        PE_rst = 1'b0;
        tick();

        // Load 3, -2, 5, -7 on row 0
        beat(4'd0, 9'sd3);
        chk("fwd_en", 32'(bus.PE_w_en_down), 32'd1);
        chk("fwd_data", 32'(bus.PE_w_data_down), 32'd3);
        beat(4'd0, -9'sd2);
        beat(4'd0, 9'sd5);
        chk("full_before_wrap", 32'(bus.PE_shadow_full), 32'd0);
        beat(4'd0, -9'sd7);
        chk("full_after_wrap", 32'(bus.PE_shadow_full), 32'd1);
        swap();
        chk("full_after_swap", 32'(bus.PE_shadow_full), 32'd0);

        // 10 * -2 + 100 = 80
        compute(9'sd10, 2'd1, 32'sd100);
        chk("mac_idx1", bus.PE_psum_down, 32'd80);
        chk("mac_en_down", 32'(bus.PE_en_down), 32'd1);
        chk("mac_en_right", 32'(bus.PE_en_right), 32'd1);
        chk("mac_data_right", 32'(bus.PE_data_right), 32'd10);
        chk("mac_idx_right", 32'(bus.PE_idx_right), 32'd1);
        tick();
        chk("idle_en_down", 32'(bus.PE_en_down), 32'd0);
        chk("idle_en_right", 32'(bus.PE_en_right), 32'd0);
        chk("idle_psum_hold", bus.PE_psum_down, 32'd80);
        // -3 * -7 - 50 = -29
        compute(-9'sd3, 2'd3, -32'sd50);
        chk("mac_idx3", bus.PE_psum_down, -32'sd29);

        // Row filter: row 1 beat forwarded, not captured; next row-0 beat goes to slot 0
        beat(4'd1, 9'sd9);
        chk("rowf_en", 32'(bus.PE_w_en_down), 32'd1);
        chk("rowf_data", 32'(bus.PE_w_data_down), 32'd9);
        chk("rowf_row", 32'(bus.PE_w_row_down), 32'd1);
        beat(4'd0, 9'sd11);
        swap();
        compute(9'sd1, 2'd0, 32'sd0);
        chk("rowf_slot0", bus.PE_psum_down, 32'd11);
        compute(9'sd1, 2'd1, 32'sd0);
        chk("shadow_retained", bus.PE_psum_down, -32'sd2);

        // Swap/compute collision: active[0]=2, shadow[0]=4
        beat(4'd0, 9'sd2);
        swap();
        beat(4'd0, 9'sd4);
        bus.PE_swap = 1'b1;
        compute(9'sd3, 2'd0, 32'sd0);
        bus.PE_swap = 1'b0;
        chk("coll_pre_swap", bus.PE_psum_down, 32'd6);
        compute(9'sd3, 2'd0, 32'sd0);
        chk("coll_post_swap", bus.PE_psum_down, 32'd12);

        // Wrap: beats 1..5 give shadow {5,2,3,4}
        for (int i = 1; i <= 5; i++) beat(4'd0, D_WIDTH'(i));
        chk("wrap_full", 32'(bus.PE_shadow_full), 32'd1);
        swap();
        compute(9'sd1, 2'd0, 32'sd0);
        chk("wrap_w0", bus.PE_psum_down, 32'd5);
        compute(9'sd1, 2'd1, 32'sd0);
        chk("wrap_w1", bus.PE_psum_down, 32'd2);
        compute(9'sd1, 2'd2, 32'sd0);
        chk("wrap_w2", bus.PE_psum_down, 32'd3);
        compute(9'sd1, 2'd3, 32'sd0);
        chk("wrap_w3", bus.PE_psum_down, 32'd4);

        // Overflow: weight 255 in slot 0
        beat(4'd0, 9'sd255);
        swap();
        compute(9'sd255, 2'd0, 32'sh7FFF_FFF0);
`ifdef PE_SAT_EN
        chk("ovf_pos", bus.PE_psum_down, 32'h7FFF_FFFF);
`else
        chk("ovf_pos", bus.PE_psum_down, 32'h8000_FDF1);
`endif
        compute(-9'sd255, 2'd0, 32'sh8000_0010);
`ifdef PE_SAT_EN
        chk("ovf_neg", bus.PE_psum_down, 32'h8000_0000);
`else
        chk("ovf_neg", bus.PE_psum_down, 32'h7FFF_020F);
`endif

        // Asynchronous reset mid-stream
        bus.PE_en_left   = 1'b1;
        bus.PE_data_left = 9'sd5;
        bus.PE_idx_left  = 2'd0;
        bus.PE_psum_up   = 32'sd1;
        bus.PE_w_en_up   = 1'b1;
        bus.PE_w_row_up  = 4'd0;
        bus.PE_w_data_up = 9'sd7;
        tick();
        #2;
        PE_rst = 1'b1;
        #1;
        chk("arst_psum_down", bus.PE_psum_down, 32'd0);
        chk("arst_en_down", 32'(bus.PE_en_down), 32'd0);
        chk("arst_en_right", 32'(bus.PE_en_right), 32'd0);
        chk("arst_data_right", 32'(bus.PE_data_right), 32'd0);
        chk("arst_w_en_down", 32'(bus.PE_w_en_down), 32'd0);
        chk("arst_w_data_down", 32'(bus.PE_w_data_down), 32'd0);
        bus.PE_w_en_up = 1'b0;
        bus.PE_en_left = 1'b0;
        tick();
        PE_rst = 1'b0;
        compute(9'sd10, 2'd0, 32'sd7);
        chk("post_rst_w0", bus.PE_psum_down, 32'd7);
        chk("post_rst_en", 32'(bus.PE_en_down), 32'd1);
        compute(9'sd10, 2'd1, 32'sd7);
        chk("post_rst_w1", bus.PE_psum_down, 32'd7);
        swap();
        compute(9'sd10, 2'd0, 32'sd7);
        chk("post_rst_shadow", bus.PE_psum_down, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop so the run always ends on its own
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pe_dbw.md
# pe_dbw

Parametrised systolic processing element with a double-buffered, multi-entry weight bank. It is the second-generation PE for the NICE CNN accelerator array. Weights stream down a dedicated load chain into a shadow bank while computation continues on the active bank. Each activation carries a weight index, so one PE can serve up to N_W time-multiplexed filters.

## Interface
- D_WIDTH, 9: signed activation/weight width.
- A_WIDTH, 32: signed partial-sum width; must be ≥ 2*D_WIDTH+1.
- N_W, 4: weight bank depth; power of two, ≥ 2. IDX_W = log2(N_W).
- R_WIDTH, 4: row-select width on the load chain.
- ROW_ID, 0: this PE's row address on the load chain.

Ports:
- PE_clk  in  1  clock, rising edge.
- PE_rst  in  1  asynchronous, active-high reset.
- PE_w_en_up  in  1  weight-load beat valid.
- PE_w_data_up  in  D_WIDTH  weight value.
- PE_w_row_up  in  R_WIDTH  target row of the beat.
- PE_w_en_down / PE_w_data_down / PE_w_row_down  out  1 / D_WIDTH / R_WIDTH  load chain, registered forward.
- PE_swap  in  1  pulse: commit shadow bank to active bank.
- PE_en_left  in  1  activation valid.
- PE_data_left  in  D_WIDTH  signed activation.
- PE_idx_left  in  IDX_W  active-bank weight index.
- PE_en_right / PE_data_right / PE_idx_right  out  1 / D_WIDTH / IDX_W  activation forward, registered.
- PE_psum_up  in  A_WIDTH  signed partial sum from above.
- PE_psum_down  out  A_WIDTH  signed partial sum result.
- PE_en_down  out  1  PE_psum_down valid.
- PE_shadow_full  out  1  all N_W shadow slots written since the last swap or reset.

## Operation
- Load chain:
  - Every beat is forwarded down, registered, regardless of row.
  - When PE_w_en_up and PE_w_row_up == ROW_ID, write PE_w_data_up into shadow[wptr], then wptr++.
  - wptr wraps from N_W-1 to 0. The wrap sets PE_shadow_full, which stays set until swap or reset.
  - Writes past N_W overwrite from slot 0.
- Swap: on PE_swap, active ← shadow (whole bank), wptr ← 0, PE_shadow_full ← 0.
  - Shadow contents are retained.
  - A shadow write in the same cycle lands in shadow at slot wptr (pre-clear) but is not copied into active.
  - Swap is permitted with a partially filled shadow.
- Compute: when PE_en_left:
  - PE_psum_down ← sext(PE_data_left * active[PE_idx_left]) + PE_psum_up.
  - PE_data_right / PE_idx_right ← inputs.
  - PE_en_right ← 1 and PE_en_down ← 1.
  - Otherwise both valid outputs go to 0, and data/psum outputs hold their last value.
- Arithmetic: the product is full 2*D_WIDTH signed, sign-extended to A_WIDTH. The add wraps modulo 2^A_WIDTH unless PE_SAT_EN is defined.
- Compute and load are independent. Compute in the swap cycle uses the pre-swap active bank.
- There is no back-pressure; all interfaces are valid-only.

## Timing
- Reset: all outputs 0; active bank, shadow bank, wptr and PE_shadow_full all 0.
- Reset mid-operation discards in-flight beats. The first post-reset compute uses weight 0, so the result equals PE_psum_up.
- Latencies:
  - Load chain: 1 cycle up→down.
  - Activation: 1 cycle left→right.
  - psum: 1 cycle.
  - A shadow write is visible in active only after a subsequent swap, at the earliest for compute 1 cycle after the swap edge.
- PE_shadow_full updates in the cycle after the wrapping write.

## Configuration
- PE_SAT_EN:
  - Defined: the final sum saturates to [-2^(A_WIDTH-1), 2^(A_WIDTH-1)-1].
  - Undefined: two's-complement wrap. The product itself never overflows.

## Test plan
- Reset: assert PE_rst mid-stream → all outputs 0 asynchronously; after release, compute data=10, idx=0, psum_up=7 → psum_down=7.
- Load/swap/compute (ROW_ID=0): load weights 3, -2, 5, -7 on row 0, then swap. Then data=10, idx=1, psum_up=100 → psum_down=80 and en_down=1 one cycle later. PE_shadow_full=1 before the swap and 0 after.
- Row filter: load beat data=9, row=1 → not captured (wptr unchanged) and forwarded on PE_w_*_down one cycle later with row=1.
- Swap/compute collision: active[0]=2, shadow[0]=4, swap and compute data=3, idx=0, psum_up=0 in the same cycle → 6. The next compute with the same inputs → 12.
- Wrap: 5 row-0 beats 1..5, then swap → active = {5, 2, 3, 4}.
- Saturation (D=9): psum_up=0x7FFFFFF0, data=255, weight=255 → 0x7FFFFFFF with PE_SAT_EN, 0x8000FDF1 without.
